// File: rtl/period_meter_pkg.sv
// Shared types and default constants for the period meter.
package period_meter_pkg;

    localparam int unsigned CLK_HZ    = 100000000;
    localparam int          CNT_W_DEF = 28;

    // One second of system clock: the longest period worth waiting for.
    localparam logic [CNT_W_DEF-1:0] TIMEOUT_DEF = CNT_W_DEF'(CLK_HZ);

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        TMO
    } state_e;

endpackage

// File: rtl/period_meter_sync_edge_detect.sv
// Multi-flop synchronizer plus history flop with rise/fall strobes; reusable
// for any asynchronous input such as buttons or external ticks.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // NOTE: sequential state uses <= so every flop samples the pre-edge value;
    // a blocking '=' here would collapse the synchronizer chain into one flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow async waveform in clk cycles.
// Define PERIOD_METER_AVG4_EN to report 4-sample running averages instead.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int             CNT_W       = CNT_W_DEF,
    parameter logic [CNT_W-1:0] TIMEOUT   = CNT_W'(TIMEOUT_DEF),
    parameter int             SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             timeout
);

    logic rise;
    logic fall;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (sig_in),
        .level(),
        .rise (rise),
        .fall (fall)
    );

    state_e           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [CNT_W-1:0] hi_cap_q, hi_cap_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q,   high_d;
    logic             valid_q,  valid_d;
    logic             tmo_q,    tmo_d;
    logic             capture;

`ifdef PERIOD_METER_AVG4_EN
    localparam int SUM_W = CNT_W + 2;

    logic [3:0][CNT_W-1:0] per_hist_q, per_hist_d;
    logic [3:0][CNT_W-1:0] hi_hist_q,  hi_hist_d;
    logic [SUM_W-1:0]      per_sum_q,  per_sum_d;
    logic [SUM_W-1:0]      hi_sum_q,   hi_sum_d;
    logic [2:0]            cap_cnt_q,  cap_cnt_d;
`endif

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; that is what keeps this block free of inferred latches.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_cap_d = hi_cap_q;
        period_d = period_q;
        high_d   = high_q;
        valid_d  = 1'b0;
        tmo_d    = tmo_q;
        capture  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    cnt_d   = CNT_W'(1);
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                cnt_d = (cnt_q == TIMEOUT) ? cnt_q : cnt_q + 1'b1;
                if (fall) hi_cap_d = cnt_q;
                // A rise on the timeout cycle still completes a valid period.
                if (rise) begin
                    capture = 1'b1;
                    cnt_d   = CNT_W'(1);
                end else if (cnt_q == TIMEOUT) begin
                    state_d = TMO;
                    tmo_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            TMO: begin
                cnt_d = '0;
                if (rise) begin
                    tmo_d   = 1'b0;
                    cnt_d   = CNT_W'(1);
                    state_d = MEASURE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

`ifdef PERIOD_METER_AVG4_EN
        per_hist_d = per_hist_q;
        hi_hist_d  = hi_hist_q;
        per_sum_d  = per_sum_q;
        hi_sum_d   = hi_sum_q;
        cap_cnt_d  = cap_cnt_q;

        if (state_d != MEASURE) begin
            per_hist_d = '0;
            hi_hist_d  = '0;
            per_sum_d  = '0;
            hi_sum_d   = '0;
            cap_cnt_d  = '0;
        end else if (capture) begin
            // Running sum: add the newest capture, drop the one leaving the window.
            per_hist_d = {per_hist_q[2:0], cnt_q};
            hi_hist_d  = {hi_hist_q[2:0], hi_cap_q};
            per_sum_d  = per_sum_q + SUM_W'(cnt_q) - SUM_W'(per_hist_q[3]);
            hi_sum_d   = hi_sum_q + SUM_W'(hi_cap_q) - SUM_W'(hi_hist_q[3]);
            if (cap_cnt_q != 3'd4) cap_cnt_d = cap_cnt_q + 3'd1;
            if (cap_cnt_q >= 3'd3) begin
                valid_d  = 1'b1;
                period_d = CNT_W'(per_sum_d >> 2);
                high_d   = CNT_W'(hi_sum_d >> 2);
            end
        end
`else
        if (capture) begin
            valid_d  = 1'b1;
            period_d = cnt_q;
            high_d   = hi_cap_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_cap_q <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_cap_q <= hi_cap_d;
            period_q <= period_d;
            high_q   <= high_d;
            valid_q  <= valid_d;
            tmo_q    <= tmo_d;
        end
    end

`ifdef PERIOD_METER_AVG4_EN
    // NOTE: the history window is reset along with everything else; a stale
    // entry would otherwise be subtracted from the sum and corrupt the average.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_hist_q <= '0;
            hi_hist_q  <= '0;
            per_sum_q  <= '0;
            hi_sum_q   <= '0;
            cap_cnt_q  <= '0;
        end else begin
            per_hist_q <= per_hist_d;
            hi_hist_q  <= hi_hist_d;
            per_sum_q  <= per_sum_d;
            hi_sum_q   <= hi_sum_d;
            cap_cnt_q  <= cap_cnt_d;
        end
    end
`endif

    assign period     = period_q;
    assign high_time  = high_q;
    assign meas_valid = valid_q;
    assign timeout    = tmo_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: TIMEOUT=1000 instance plus a default-TIMEOUT
// instance sharing the same stimulus.
module tb_period_meter;

    localparam int CNT_W = 28;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sig_in = 1'b0;
    logic [CNT_W-1:0] period, high_time;
    logic             meas_valid, timeout;
    logic [CNT_W-1:0] period_def, high_time_def;
    logic             meas_valid_def, timeout_def;

    period_meter #(
        .CNT_W      (CNT_W),
        .TIMEOUT    (28'd1000),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .timeout   (timeout)
    );

    period_meter #(
        .SYNC_STAGES(2)
    ) dut_def (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .period    (period_def),
        .high_time (high_time_def),
        .meas_valid(meas_valid_def),
        .timeout   (timeout_def)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Result collector: latches every reported measurement.
    int               vc = 0, vc_def = 0, dbl = 0, tmo_rises = 0;
    logic [CNT_W-1:0] last_per = '0, last_hi = '0, last_per_def = '0, last_hi_def = '0;
    logic             prev_valid = 1'b0, prev_tmo = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (meas_valid) begin
                vc++;
                last_per = period;
                last_hi  = high_time;
            end
            if (meas_valid_def) begin
                vc_def++;
                last_per_def = period_def;
                last_hi_def  = high_time_def;
            end
            if (meas_valid && prev_valid) dbl++;
            if (timeout && !prev_tmo) tmo_rises++;
            prev_valid = meas_valid;
            prev_tmo   = timeout;
        end else begin
            prev_valid = 1'b0;
            prev_tmo   = 1'b0;
        end
    end

    // One waveform period starting with a rising edge, driven on negedges.
    task automatic pulse(input int p, input int h);
        sig_in = 1'b1;
        repeat (h) @(negedge clk);
        sig_in = 1'b0;
        repeat (p - h) @(negedge clk);
    endtask

    int vc0;
    int tr0;
    int tmo_n;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_period", period, 0);
        check("rst_high", high_time, 0);
        check("rst_valid", meas_valid, 0);
        check("rst_timeout", timeout, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

`ifdef PERIOD_METER_AVG4_EN
        pulse(100, 50);
        pulse(102, 50);
        pulse(104, 50);
        pulse(106, 50);
        check("avg_no_early_valid", vc, 0);
        pulse(108, 50);
        check("avg_first_cnt", vc, 1);
        check("avg_first_per", last_per, 103);
        check("avg_first_hi", last_hi, 50);
        pulse(110, 50);
        check("avg_second_per", last_per, 105);
        pulse(200, 50);
        check("avg_third_cnt", vc, 3);
        check("avg_third_per", last_per, 107);
        check("avg_third_hi", last_hi, 50);
`else
        // Steady 200/50 wave: first rise only arms.
        pulse(200, 50);
        check("arm_no_valid", vc, 0);
        repeat (3) pulse(200, 50);
        check("wave_valid_cnt", vc, 3);
        check("wave_period", last_per, 200);
        check("wave_high", last_hi, 50);
        check("wave_timeout", timeout, 0);

        // Last rise then hold low: timeout 1000 cycles after detection.
        tmo_n  = 0;
        sig_in = 1'b1;
        for (int n = 1; n <= 1100 && tmo_n == 0; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 50) sig_in = 1'b0;
            if (timeout) tmo_n = n;
        end
        check("tmo_latency", tmo_n, 1003);
        check("tmo_period_kept", period, 200);
        vc0 = vc;
        pulse(100, 50);
        check("tmo_cleared", timeout, 0);
        check("tmo_rearm_no_valid", vc - vc0, 0);
        pulse(100, 50);
        check("resume_cnt", vc - vc0, 1);
        check("resume_period", last_per, 100);

        // Boundary: exactly TIMEOUT apart reports; TIMEOUT+1 times out.
        vc0 = vc;
        tr0 = tmo_rises;
        repeat (3) pulse(1000, 50);
        check("edge1000_cnt", vc - vc0, 3);
        check("edge1000_period", last_per, 1000);
        check("edge1000_no_tmo", tmo_rises - tr0, 0);
        vc0 = vc;
        pulse(1001, 50);
        pulse(300, 100);
        check("edge1001_report_cnt", vc - vc0, 1);
        check("edge1001_tmo_seen", tmo_rises - tr0, 1);
        check("edge1001_period_kept", period, 1000);
        check("edge1001_tmo_cleared", timeout, 0);

        // Reset mid-period.
        sig_in = 1'b1;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_period", period, 0);
        check("midrst_high", high_time, 0);
        check("midrst_valid", meas_valid, 0);
        check("midrst_timeout", timeout, 0);
        sig_in = 1'b0;
        rst_n  = 1'b1;
        vc0    = vc;
        pulse(300, 100);
        check("postrst_arm", vc - vc0, 0);
        pulse(300, 100);
        check("postrst_cnt", vc - vc0, 1);
        check("postrst_period", last_per, 300);
        check("postrst_high", last_hi, 100);

        // Long period: times out on the small instance, measured by the default one.
        vc0 = vc;
        repeat (2) pulse(3000, 1500);
        check("def_period", last_per_def, 3000);
        check("def_high", last_hi_def, 1500);
        check("def_timeout", timeout_def, 0);
        check("small_timeout", timeout, 1);
        check("small_one_report", vc - vc0, 1);
        check("small_period_kept", period, 300);
`endif

        check("valid_single_cycle", dbl, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
